// File: rtl/psum_resolve_drain_if.sv
// Handshake bundle between the column accumulator, the resolve pipeline
// and the writeback drain.
interface psum_resolve_drain_if #(
    parameter int PSUM_W = 20,
    parameter int OUT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PSUM_W-1:0] psum0;
    logic [PSUM_W-1:0] psum1;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;
    logic              out_last;

    modport master (
        output in_valid, psum0, psum1, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_last
    );

    modport slave (
        input  in_valid, psum0, psum1, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_last
    );
endinterface

// File: rtl/psum_resolve_drain.sv
// Resolves a carry-save partial-sum pair to a saturated binary result and
// buffers it in a 4-entry credit-managed drain FIFO.
module psum_resolve_drain #(
    parameter int ARRAYSIZE = 16,
    parameter int OUT_W     = 16,
    parameter logic [$clog2(ARRAYSIZE)+15:0] BIAS_CORR = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    psum_resolve_drain_if.slave    io,
    output logic [15:0]            sat_cnt,
    input  logic                   sat_clr
);
    localparam int PSUM_W = $clog2(ARRAYSIZE) + 16;
    localparam int L      = PSUM_W / 2;
    localparam int H      = PSUM_W - L;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sat;
        logic             last;
    } ent_t;

    logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic              s1_cout_q, s1_cout_d;
    logic [L-1:0]      s1_lo_q, s1_lo_d;
    logic [H-1:0]      s1_hi_a_q, s1_hi_a_d, s1_hi_b_q, s1_hi_b_d;
    logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [PSUM_W-1:0] s2_sum_q, s2_sum_d;
    logic              s3_valid_q, s3_valid_d;
    ent_t              s3_ent_q, s3_ent_d;
    ent_t              mem_q [4];
    ent_t              mem_d [4];
    logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]        count_q, count_d;
    logic [15:0]       sat_cnt_q, sat_cnt_d;

    logic              accept, push, pop;
    logic [PSUM_W-1:0] csa_s, csa_maj, csa_c;
    logic [PSUM_W-OUT_W:0] hi_bits;
    logic [3:0]        occ;

    // Credit counts everything already committed to a FIFO slot.
    always_comb begin
        occ = {1'b0, count_q} + 4'(s1_valid_q) + 4'(s2_valid_q)
            + 4'(s3_valid_q);
        io.in_ready = occ < 4'd4;
        accept = io.in_valid && io.in_ready;
        io.out_valid = count_q != 3'd0;
        pop = io.out_valid && io.out_ready;
        push = s3_valid_q;
        io.out_data = mem_q[rd_ptr_q].data;
        io.out_sat = mem_q[rd_ptr_q].sat;
        io.out_last = mem_q[rd_ptr_q].last;
        sat_cnt = sat_cnt_q;
    end

    always_comb begin
        csa_s = io.psum0 ^ io.psum1 ^ BIAS_CORR;
        csa_maj = (io.psum0 & io.psum1) | (io.psum0 & BIAS_CORR)
                | (io.psum1 & BIAS_CORR);
        csa_c = {csa_maj[PSUM_W-2:0], 1'b0};
        {s1_cout_d, s1_lo_d} = {1'b0, csa_s[L-1:0]} + {1'b0, csa_c[L-1:0]};
        s1_hi_a_d = csa_s[PSUM_W-1:L];
        s1_hi_b_d = csa_c[PSUM_W-1:L];
        s1_valid_d = accept;
        s1_last_d = io.in_last;
    end

    always_comb begin
        s2_sum_d = {s1_hi_a_q + s1_hi_b_q + H'(s1_cout_q), s1_lo_q};
        s2_valid_d = s1_valid_q;
        s2_last_d = s1_last_q;
    end

    // In-range iff every bit above the output sign bit matches the sign.
    always_comb begin
        hi_bits = s2_sum_q[PSUM_W-1:OUT_W-1];
        s3_ent_d.data = s2_sum_q[OUT_W-1:0];
        s3_ent_d.sat = 1'b0;
        s3_ent_d.last = s2_last_q;
        if (s2_sum_q[PSUM_W-1] && !(&hi_bits)) begin
            s3_ent_d.data = {1'b1, {(OUT_W-1){1'b0}}};
            s3_ent_d.sat = 1'b1;
        end else if (!s2_sum_q[PSUM_W-1] && (|hi_bits)) begin
            s3_ent_d.data = {1'b0, {(OUT_W-1){1'b1}}};
            s3_ent_d.sat = 1'b1;
        end
        s3_valid_d = s2_valid_q;
    end

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = s3_ent_q;
        wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d = count_q + 3'(push) - 3'(pop);
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) sat_cnt_d = '0;
        else if (push && s3_ent_q.sat && sat_cnt_q != 16'hFFFF)
            sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_cout_q  <= 1'b0;
            s1_lo_q    <= '0;
            s1_hi_a_q  <= '0;
            s1_hi_b_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_sum_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_ent_q   <= '0;
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sat_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_cout_q  <= s1_cout_d;
            s1_lo_q    <= s1_lo_d;
            s1_hi_a_q  <= s1_hi_a_d;
            s1_hi_b_q  <= s1_hi_b_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_sum_q   <= s2_sum_d;
            s3_valid_q <= s3_valid_d;
            s3_ent_q   <= s3_ent_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end
endmodule

// File: tb/tb_psum_resolve_drain.sv
// Self-checking bench: directed table, flow-control and reset sequences,
// plus a randomized stream checked against an arithmetic reference model.
module tb_psum_resolve_drain;
    localparam logic [19:0] BIAS = 20'h0;

    typedef struct packed {
        logic [15:0] d;
        logic        sat;
        logic        last;
    } ent_t;

    typedef struct {
        logic [19:0] p0;
        logic [19:0] p1;
        logic [15:0] d;
        logic        sat;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sat_clr = 1'b0;
    logic [15:0] sat_cnt;

    psum_resolve_drain_if #(.PSUM_W(20), .OUT_W(16)) bus ();

    psum_resolve_drain #(.ARRAYSIZE(16), .OUT_W(16), .BIAS_CORR(BIAS)) dut (
        .clk(clk), .rst(rst), .io(bus), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    ent_t exp_q [$];
    int acc_cnt = 0;
    int pop_cnt = 0;
    logic [15:0] mdl_sat = '0;

    function automatic ent_t model(input logic [19:0] a, input logic [19:0] b,
                                   input logic last);
        logic signed [19:0] s;
        ent_t e;
        s = $signed(a + b + BIAS);
        e.last = last;
        if (s > 20'sd32767) begin
            e.d = 16'h7FFF; e.sat = 1'b1;
        end else if (s < -20'sd32768) begin
            e.d = 16'h8000; e.sat = 1'b1;
        end else begin
            e.d = s[15:0]; e.sat = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard and hold-stability checker, sampled mid-cycle.
    logic prev_stall = 1'b0;
    ent_t prev_head;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_head", 32'({bus.out_data, bus.out_sat, bus.out_last}),
                      32'(prev_head));
            end
            if (bus.in_valid && bus.in_ready) begin
                ent_t e;
                e = model(bus.psum0, bus.psum1, bus.in_last);
                exp_q.push_back(e);
                acc_cnt++;
                if (e.sat && mdl_sat != 16'hFFFF) mdl_sat = mdl_sat + 16'd1;
            end
            if (bus.out_valid && bus.out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    check("pop_entry",
                          32'({bus.out_data, bus.out_sat, bus.out_last}),
                          32'(exp_q.pop_front()));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_head = {bus.out_data, bus.out_sat, bus.out_last};
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Holds one pair until accepted; returns at accept edge + 1.
    task automatic send(input logic [19:0] a, input logic [19:0] b,
                        input logic last);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1; bus.psum0 = a; bus.psum1 = b; bus.in_last = last;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check(name, 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) begin ok = 1'b1; break; end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    vec_t tbl [8];

    initial begin
        int acc;
        int stale;
        int sent;
        int p0base;
        logic [19:0] ra, rb;

        tbl[0] = '{20'h7FFFF, 20'h00001, 16'h8000, 1'b1, 16'd1};
        tbl[1] = '{20'h0FFFF, 20'h00001, 16'h7FFF, 1'b1, 16'd2};
        tbl[2] = '{20'h00010, 20'hFFFF0, 16'h0000, 1'b0, 16'd2};
        tbl[3] = '{20'h07FFF, 20'h00000, 16'h7FFF, 1'b0, 16'd2};
        tbl[4] = '{20'hF8000, 20'h00000, 16'h8000, 1'b0, 16'd2};
        tbl[5] = '{20'hF7FFF, 20'h00000, 16'h8000, 1'b1, 16'd3};
        tbl[6] = '{20'h08000, 20'h00000, 16'h7FFF, 1'b1, 16'd4};
        tbl[7] = '{20'hFFFFF, 20'hFFFFF, 16'hFFFE, 1'b0, 16'd4};

        bus.in_valid = 1'b0; bus.psum0 = '0; bus.psum1 = '0;
        bus.in_last = 1'b0; bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_sat", 32'(bus.out_sat), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
        rst = 1'b0;
        sync();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // First result latency
        bus.out_ready = 1'b1;
        send(20'h00010, 20'h00005, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("latency_valid", 32'(bus.out_valid), (k == 4) ? 32'd1 : 32'd0);
        end
        check("first_data", 32'(bus.out_data), 32'h15);
        check("first_sat", 32'(bus.out_sat), 32'd0);
        check("first_last", 32'(bus.out_last), 32'd1);

        // Directed saturation table
        for (int i = 0; i < 8; i++) begin
            sync();
            send(tbl[i].p0, tbl[i].p1, 1'(i));
            wait_out("tbl_timeout");
            check("tbl_data", 32'(bus.out_data), 32'(tbl[i].d));
            check("tbl_sat", 32'(bus.out_sat), 32'(tbl[i].sat));
            check("tbl_sat_cnt", 32'(sat_cnt), 32'(tbl[i].cnt));
        end
        sync();

        // Backpressure: only four credits
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            bus.psum0 = 20'(i * 3 + 1); bus.psum1 = 20'h2; bus.in_last = 1'(i);
            @(negedge clk);
            if (bus.in_ready) acc++;
            sync();
        end
        check("full_accepts", 32'(acc), 32'd4);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        p0base = pop_cnt;
        drain("full_drain");
        check("full_pops", 32'(pop_cnt - p0base), 32'd4);
        sync();

        // Random back-to-back stream
        sent = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3000 && sent < 64; c++) begin
            ra = 20'($urandom); rb = 20'($urandom);
            if ($urandom_range(0, 1) == 1) ra = {{5{ra[14]}}, ra[14:0]};
            if ($urandom_range(0, 1) == 1) rb = {{5{rb[14]}}, rb[14:0]};
            bus.psum0 = ra; bus.psum1 = rb;
            bus.in_last = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_ready) sent++;
            sync();
        end
        check("rand_sent", 32'(sent), 32'd64);
        drain("rand_drain");
        check("rand_sat_cnt", 32'(sat_cnt), 32'(mdl_sat));
        sync();

        // Reset with two buffered and two in flight
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.psum0 = 20'h7FFFF; bus.psum1 = 20'h1;
        bus.in_last = 1'b0;
        repeat (4) sync();
        bus.in_valid = 1'b0;
        sync();
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_sat_cnt", 32'(sat_cnt), 32'd0);
        exp_q.delete();
        mdl_sat = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("rst_no_stale", 32'(stale), 32'd0);
        sync();
        send(20'h00100, 20'h00023, 1'b1);
        wait_out("post_rst_timeout");
        check("post_rst_data", 32'(bus.out_data), 32'h123);
        sync();

        // Saturating stream up to the counter ceiling
        p0base = acc_cnt;
        bus.in_valid = 1'b1; bus.psum0 = 20'h7FFFF; bus.psum1 = 20'h1;
        bus.in_last = 1'b0;
        for (int c = 0; c < 90000 && (acc_cnt - p0base) < 65540; c++)
            @(negedge clk);
        sync();
        check("stream_count", 32'(acc_cnt - p0base), 32'd65540);
        drain("stream_drain");
        check("sat_cnt_hold", 32'(sat_cnt), 32'hFFFF);
        check("sat_cnt_model", 32'(sat_cnt), 32'(mdl_sat));
        sync();

        // Clear coincident with a saturation event
        send(20'h7FFFF, 20'h1, 1'b0);
        sync();
        @(posedge clk); #1 sat_clr = 1'b1;
        @(posedge clk); #1 sat_clr = 1'b0;
        check("clr_push_valid", 32'(bus.out_valid), 32'd1);
        check("clr_sat_cnt", 32'(sat_cnt), 32'd0);
        mdl_sat = '0;
        sync();
        send(20'h0FFFF, 20'h1, 1'b0);
        wait_out("after_clr_timeout");
        check("after_clr_cnt", 32'(sat_cnt), 32'd1);
        drain("final_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
